// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ byte-transfer clients.
// Sequences the controller register bus for the winner and returns its RX byte and status.
module spi_xfer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_lsb_first,
  input  logic [8*NUM_REQ-1:0] req_clk_div,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic                 spi_cs_n,
  output logic [7:0]           spi_reg_addr,
  output logic                 spi_reg_write,
  output logic [7:0]           spi_reg_wdata,
  input  logic [7:0]           spi_reg_rdata,
  input  logic                 spi_ready
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [3:0] {
    IDLE, WR_DIV, WR_TX, WR_EN, WAIT_BSY, WAIT_RDY, RD_RX, WR_DIS, DONE
  } state_t;

  state_t        state, nxt_state;
  logic [IW-1:0] idx, nxt_idx, win_idx, rr_ptr;
  logic [IW:0]   cand;
  logic          win_found;
  logic [CW-1:0] cnt;
  logic          tmo;
  logic          nxt_write;
  logic [7:0]    nxt_addr, nxt_wdata;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!win_found && req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    tmo       = 1'b0;
    unique case (state)
      IDLE:     if (win_found) begin
                  nxt_state = WR_DIV;
                  nxt_idx   = win_idx;
                end
      WR_DIV:   nxt_state = WR_TX;
      WR_TX:    nxt_state = WR_EN;
      WR_EN:    nxt_state = WAIT_BSY;
      WAIT_BSY: if (!spi_ready) nxt_state = WAIT_RDY;
                else if (cnt == CW'(TIMEOUT-1)) begin
                  nxt_state = WR_DIS;
                  tmo       = 1'b1;
                end
      WAIT_RDY: if (spi_ready) nxt_state = RD_RX;
                else if (cnt == CW'(TIMEOUT-1)) begin
                  nxt_state = WR_DIS;
                  tmo       = 1'b1;
                end
      RD_RX:    nxt_state = WR_DIS;
      WR_DIS:   nxt_state = DONE;
      DONE:     nxt_state = IDLE;
      default:  nxt_state = IDLE;
    endcase
  end

  // NOTE: bus outputs are decoded from the next state and registered, so each
  // register access is presented glitch-free for exactly the cycle of its state.
  always_comb begin
    nxt_write = 1'b0;
    nxt_addr  = 8'h00;
    nxt_wdata = 8'h00;
    case (nxt_state)
      WR_DIV: begin nxt_write = 1'b1; nxt_addr = 8'h10; nxt_wdata = req_clk_div[8*nxt_idx +: 8]; end
      WR_TX:  begin nxt_write = 1'b1; nxt_addr = 8'h08; nxt_wdata = req_wdata[8*nxt_idx +: 8]; end
      WR_EN:  begin
                nxt_write = 1'b1;
                nxt_addr  = 8'h00;
                nxt_wdata = {5'b0, req_lsb_first[nxt_idx], 2'b11};
              end
      RD_RX:  nxt_addr = 8'h0C;
      WR_DIS: begin nxt_write = 1'b1; nxt_addr = 8'h00; nxt_wdata = 8'h02; end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      rr_ptr        <= '0;
      cnt           <= '0;
      err           <= 1'b0;
      rdata         <= 8'h00;
      spi_reg_write <= 1'b0;
      spi_reg_addr  <= 8'h00;
      spi_reg_wdata <= 8'h00;
    end else begin
      state         <= nxt_state;
      idx           <= nxt_idx;
      spi_reg_write <= nxt_write;
      spi_reg_addr  <= nxt_addr;
      spi_reg_wdata <= nxt_wdata;
      if ((nxt_state == WAIT_BSY || nxt_state == WAIT_RDY) && nxt_state != state) cnt <= '0;
      else if (state == WAIT_BSY || state == WAIT_RDY) cnt <= cnt + 1'b1;
      if (state == IDLE && win_found) err <= 1'b0;
      else if (tmo) err <= 1'b1;
      if (state == RD_RX) rdata <= spi_reg_rdata;
      if (state == DONE) rr_ptr <= (idx == IW'(NUM_REQ-1)) ? '0 : idx + 1'b1;
    end
  end

  assign busy     = (state != IDLE);
  assign spi_cs_n = (state == IDLE) || (state == DONE);
  assign gnt      = busy ? (ONE << idx) : '0;
  assign done     = (state == DONE) ? (ONE << idx) : '0;

endmodule
